// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - two-port arbiter sharing one ALU, one operation in flight
// IDLE grants and latches operands, EXEC lets the ALU settle, RESP holds the captured result until taken.
module alu_share_arbiter #(
  parameter bit RR_EN = 1'b1,
  parameter int OPW   = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [1:0]     req_valid,
  output logic [1:0]     req_ready,
  input  logic [OPW-1:0] req_op0,
  input  logic [OPW-1:0] req_op1,
  input  logic [31:0]    req_a0,
  input  logic [31:0]    req_a1,
  input  logic [31:0]    req_b0,
  input  logic [31:0]    req_b1,
  output logic [1:0]     rsp_valid,
  input  logic [1:0]     rsp_ready,
  output logic [31:0]    rsp_result,
  output logic           rsp_zero,
  output logic           rsp_negative,
  output logic [OPW-1:0] alu_op,
  output logic [31:0]    alu_a,
  output logic [31:0]    alu_b,
  input  logic [31:0]    alu_result,
  input  logic           alu_zero,
  input  logic           alu_negative,
  output logic           busy
);

  localparam logic [OPW-1:0] ALU_ADD = '0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_next_state;
  logic           r_gnt;
  logic           r_last_grant;
  logic [OPW-1:0] r_alu_op;
  logic [31:0]    r_alu_a;
  logic [31:0]    r_alu_b;
  logic [31:0]    r_rsp_result;
  logic           r_rsp_zero;
  logic           r_rsp_negative;

  logic           w_grant;
  logic           w_accept;
  logic           w_rsp_done;

  // A tie goes to the port that did not win last time, unless fixed priority is selected.
  always_comb begin
    w_grant = 1'b0;
    if (req_valid == 2'b11) begin
      w_grant = RR_EN ? ~r_last_grant : 1'b0;
    end else begin
      w_grant = req_valid[1];
    end
  end

  // Reset dominates a simultaneous request, so no accept is ever signalled while rst is high.
  assign w_accept   = (r_state == S_IDLE) && (req_valid != 2'b00) && !rst;
  assign w_rsp_done = (r_state == S_RESP) && rsp_ready[r_gnt];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next_state = S_EXEC;
      S_EXEC:  w_next_state = S_RESP;
      S_RESP:  if (w_rsp_done) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    busy      = (r_state != S_IDLE);
    case (r_state)
      S_IDLE:  if (w_accept) req_ready[w_grant] = 1'b1;
      S_RESP:  rsp_valid[r_gnt] = 1'b1;
      default: ;
    endcase
  end

  // Operands are sampled only on accept and then held until the next accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_gnt        <= 1'b0;
      r_last_grant <= 1'b1;
      r_alu_op     <= ALU_ADD;
      r_alu_a      <= 32'd0;
      r_alu_b      <= 32'd0;
    end else if (w_accept) begin
      r_gnt        <= w_grant;
      r_last_grant <= w_grant;
      r_alu_op     <= w_grant ? req_op1 : req_op0;
      r_alu_a      <= w_grant ? req_a1  : req_a0;
      r_alu_b      <= w_grant ? req_b1  : req_b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_result   <= 32'd0;
      r_rsp_zero     <= 1'b0;
      r_rsp_negative <= 1'b0;
    end else if (r_state == S_EXEC) begin
      r_rsp_result   <= alu_result;
      r_rsp_zero     <= alu_zero;
      r_rsp_negative <= alu_negative;
    end
  end

  assign alu_op       = r_alu_op;
  assign alu_a        = r_alu_a;
  assign alu_b        = r_alu_b;
  assign rsp_result   = r_rsp_result;
  assign rsp_zero     = r_rsp_zero;
  assign rsp_negative = r_rsp_negative;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - bench for alu_share_arbiter, round-robin and fixed-priority instances
module tb_alu_share_arbiter;

  localparam int OPW = 4;
  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_SLTU = 4'd6;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  rsp_ready;
  logic [3:0]  req_op0, req_op1;
  logic [31:0] req_a0, req_a1, req_b0, req_b1;

  // index 0 = round-robin instance, index 1 = fixed-priority instance
  logic [1:0]  req_ready    [2];
  logic [1:0]  rsp_valid    [2];
  logic [31:0] rsp_result   [2];
  logic        rsp_zero     [2];
  logic        rsp_negative [2];
  logic [3:0]  alu_op       [2];
  logic [31:0] alu_a        [2];
  logic [31:0] alu_b        [2];
  logic [31:0] alu_result   [2];
  logic        alu_zero     [2];
  logic        alu_negative [2];
  logic        busy         [2];

  function automatic logic [33:0] alu_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_SLT:  r = {31'd0, ($signed(a) < $signed(b))};
      OP_SLTU: r = {31'd0, (a < b)};
      default: r = a;
    endcase
    return {((op == OP_SUB) && (r == 32'd0)), r[31], r};
  endfunction

  assign {alu_zero[0], alu_negative[0], alu_result[0]} = alu_model(alu_op[0], alu_a[0], alu_b[0]);
  assign {alu_zero[1], alu_negative[1], alu_result[1]} = alu_model(alu_op[1], alu_a[1], alu_b[1]);

  alu_share_arbiter #(.RR_EN(1'b1), .OPW(OPW)) dut_rr (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready[0]),
    .req_op0(req_op0), .req_op1(req_op1),
    .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result[0]), .rsp_zero(rsp_zero[0]), .rsp_negative(rsp_negative[0]),
    .alu_op(alu_op[0]), .alu_a(alu_a[0]), .alu_b(alu_b[0]),
    .alu_result(alu_result[0]), .alu_zero(alu_zero[0]), .alu_negative(alu_negative[0]),
    .busy(busy[0])
  );

  alu_share_arbiter #(.RR_EN(1'b0), .OPW(OPW)) dut_fp (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready[1]),
    .req_op0(req_op0), .req_op1(req_op1),
    .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result[1]), .rsp_zero(rsp_zero[1]), .rsp_negative(rsp_negative[1]),
    .alu_op(alu_op[1]), .alu_a(alu_a[1]), .alu_b(alu_b[1]),
    .alu_result(alu_result[1]), .alu_zero(alu_zero[1]), .alu_negative(alu_negative[1]),
    .busy(busy[1])
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int          port;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    logic        n;
  } vec_t;

  vec_t vt [8];

  function automatic int pick(input logic [1:0] v, input int last, input bit rr);
    if (v == 2'b11) return rr ? (1 - last) : 0;
    return v[1] ? 1 : 0;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = 2'b00; rsp_ready = 2'b00;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    logic [1:0] oh;
    oh = (v.port == 1) ? 2'b10 : 2'b01;
    @(negedge clk);
    req_valid = oh; rsp_ready = oh;
    if (v.port == 1) begin req_op1 = v.op; req_a1 = v.a; req_b1 = v.b; end
    else             begin req_op0 = v.op; req_a0 = v.a; req_b0 = v.b; end
    #1 chk("vec req_ready", req_ready[0], oh);
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    chk("vec exec busy", busy[0], 1);
    chk("vec exec rsp_valid", rsp_valid[0], 0);
    chk("vec alu_op", alu_op[0], v.op);
    chk("vec alu_a", alu_a[0], v.a);
    chk("vec alu_b", alu_b[0], v.b);
    @(negedge clk);
    #1;
    chk("vec rsp_valid", rsp_valid[0], oh);
    chk("vec rsp_result", rsp_result[0], v.res);
    chk("vec rsp_zero", rsp_zero[0], v.z);
    chk("vec rsp_negative", rsp_negative[0], v.n);
    @(negedge clk);
    #1 chk("vec back to idle", busy[0], 0);
  endtask

  int          m_fly  [2];
  int          m_age  [2];
  int          m_g    [2];
  int          m_last [2];
  logic [3:0]  m_op   [2];
  logic [31:0] m_a    [2];
  logic [31:0] m_b    [2];
  logic [1:0]  exp_rdy;
  logic [33:0] exp_alu;
  int          g;

  initial begin
    rst = 1'b1; req_valid = 2'b00; rsp_ready = 2'b00;
    req_op0 = 4'd0; req_op1 = 4'd0;
    req_a0 = 32'd0; req_a1 = 32'd0; req_b0 = 32'd0; req_b1 = 32'd0;

    vt[0] = '{0, OP_ADD,  32'd5,          32'd7,          32'd12,         1'b0, 1'b0};
    vt[1] = '{1, OP_SUB,  32'd0,          32'd1,          32'hFFFF_FFFF,  1'b0, 1'b1};
    vt[2] = '{0, OP_SUB,  32'd9,          32'd9,          32'd0,          1'b1, 1'b0};
    vt[3] = '{1, OP_SLT,  32'd3,          32'd4,          32'd1,          1'b0, 1'b0};
    vt[4] = '{0, OP_SLT,  32'hFFFF_FFFF,  32'd1,          32'd1,          1'b0, 1'b0};
    vt[5] = '{1, OP_SLTU, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0, 1'b0};
    vt[6] = '{0, OP_ADD,  32'h7FFF_FFFF,  32'd1,          32'h8000_0000,  1'b0, 1'b1};
    vt[7] = '{1, OP_XOR,  32'hA5A5_A5A5,  32'hFFFF_0000,  32'h5A5A_A5A5,  1'b0, 1'b0};

    do_reset();
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("reset req_ready", req_ready[k], 0);
      chk("reset rsp_valid", rsp_valid[k], 0);
      chk("reset busy", busy[k], 0);
      chk("reset rsp_result", rsp_result[k], 0);
      chk("reset rsp_zero", rsp_zero[k], 0);
      chk("reset rsp_negative", rsp_negative[k], 0);
      chk("reset alu_op", alu_op[k], OP_ADD);
      chk("reset alu_a", alu_a[k], 0);
      chk("reset alu_b", alu_b[k], 0);
    end

    for (int i = 0; i < 8; i++) run_vec(vt[i]);

    // Both ports valid continuously: round-robin alternates, fixed priority always picks port 0.
    do_reset();
    req_op0 = OP_SUB; req_a0 = 32'd9; req_b0 = 32'd9;
    req_op1 = OP_SLT; req_a1 = 32'd3; req_b1 = 32'd4;
    req_valid = 2'b11; rsp_ready = 2'b11;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("alt rr req_ready", req_ready[0], (i % 2) ? 2'b10 : 2'b01);
      chk("alt fp req_ready", req_ready[1], 2'b01);
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("alt rr rsp_valid", rsp_valid[0], (i % 2) ? 2'b10 : 2'b01);
      chk("alt rr rsp_result", rsp_result[0], (i % 2) ? 32'd1 : 32'd0);
      chk("alt rr rsp_zero", rsp_zero[0], (i % 2) ? 1'b0 : 1'b1);
      chk("alt fp rsp_valid", rsp_valid[1], 2'b01);
      chk("alt fp rsp_result", rsp_result[1], 0);
      @(negedge clk);
    end
    req_valid = 2'b00;

    // Response backpressure with the non-granted rsp_ready bit set and port 1 waiting.
    req_valid = 2'b01; req_op0 = OP_ADD; req_a0 = 32'd100; req_b0 = 32'd23; rsp_ready = 2'b00;
    #1 chk("bp accept", req_ready[0], 2'b01);
    @(negedge clk);
    req_valid = 2'b10; req_op1 = OP_ADD; req_a1 = 32'd1; req_b1 = 32'd1;
    #1 chk("bp exec req_ready", req_ready[0], 0);
    @(negedge clk);
    for (int j = 0; j < 5; j++) begin
      rsp_ready = 2'b10;
      #1;
      chk("bp rsp_valid", rsp_valid[0], 2'b01);
      chk("bp rsp_result", rsp_result[0], 32'd123);
      chk("bp alu_a", alu_a[0], 32'd100);
      chk("bp alu_b", alu_b[0], 32'd23);
      chk("bp req_ready", req_ready[0], 0);
      @(negedge clk);
    end
    rsp_ready = 2'b01;
    #1 chk("bp last rsp_valid", rsp_valid[0], 2'b01);
    @(negedge clk);
    #1;
    chk("bp done busy", busy[0], 0);
    chk("bp done rsp_valid", rsp_valid[0], 0);
    chk("bp next grant", req_ready[0], 2'b10);
    req_valid = 2'b00;

    // Reset while in EXEC, with both ports requesting during reset.
    rsp_ready = 2'b11;
    req_valid = 2'b01; req_op0 = OP_SUB; req_a0 = 32'd50; req_b0 = 32'd8;
    @(negedge clk);
    #1 chk("rst exec busy", busy[0], 1);
    rst = 1'b1; req_valid = 2'b11;
    #1 chk("rst req_ready", req_ready[0], 0);
    @(negedge clk);
    #1;
    chk("rst abort busy", busy[0], 0);
    chk("rst abort rsp_valid", rsp_valid[0], 0);
    chk("rst abort alu_op", alu_op[0], OP_ADD);
    chk("rst abort alu_a", alu_a[0], 0);
    chk("rst abort rsp_result", rsp_result[0], 0);
    chk("rst with valid req_ready", req_ready[0], 0);
    @(negedge clk);
    rst = 1'b0;
    req_op0 = OP_ADD; req_a0 = 32'd10; req_b0 = 32'd20;
    #1;
    chk("rst no accept", busy[0], 0);
    chk("rst tie to port0", req_ready[0], 2'b01);
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    #1;
    chk("rst new rsp_valid", rsp_valid[0], 2'b01);
    chk("rst new rsp_result", rsp_result[0], 32'd30);
    @(negedge clk);

    // Randomized traffic against a transaction-level model of both instances.
    do_reset();
    for (int k = 0; k < 2; k++) begin
      m_fly[k] = 0; m_age[k] = 0; m_g[k] = 0; m_last[k] = 1;
      m_op[k] = 4'd0; m_a[k] = 32'd0; m_b[k] = 32'd0;
    end
    for (int cyc = 0; cyc < 800; cyc++) begin
      if (cyc > 0) @(negedge clk);
      rst       = ($urandom_range(0, 59) == 0);
      req_valid = 2'($urandom_range(0, 3));
      rsp_ready = 2'($urandom_range(0, 3));
      req_op0   = 4'($urandom_range(0, 6));
      req_op1   = 4'($urandom_range(0, 6));
      req_a0    = $urandom_range(0, 1) ? 32'($urandom_range(0, 9)) : $urandom;
      req_b0    = $urandom_range(0, 1) ? 32'($urandom_range(0, 9)) : $urandom;
      req_a1    = $urandom_range(0, 1) ? 32'($urandom_range(0, 9)) : $urandom;
      req_b1    = $urandom_range(0, 1) ? 32'($urandom_range(0, 9)) : $urandom;
      #1;
      for (int k = 0; k < 2; k++) begin
        exp_rdy = 2'b00;
        if (m_fly[k] == 0 && req_valid != 2'b00 && !rst) begin
          g = pick(req_valid, m_last[k], (k == 0));
          exp_rdy = (g == 1) ? 2'b10 : 2'b01;
        end
        chk("rnd req_ready", req_ready[k], exp_rdy);
        if (!rst) begin
          chk("rnd busy", busy[k], m_fly[k]);
          if (m_fly[k] != 0 && m_age[k] >= 2) begin
            exp_alu = alu_model(m_op[k], m_a[k], m_b[k]);
            chk("rnd rsp_valid", rsp_valid[k], (m_g[k] == 1) ? 2'b10 : 2'b01);
            chk("rnd rsp_result", rsp_result[k], exp_alu[31:0]);
            chk("rnd rsp_negative", rsp_negative[k], exp_alu[32]);
            chk("rnd rsp_zero", rsp_zero[k], exp_alu[33]);
          end else begin
            chk("rnd rsp_valid idle", rsp_valid[k], 0);
          end
        end
        if (rst) begin
          m_fly[k] = 0; m_last[k] = 1;
        end else if (m_fly[k] == 0 && req_valid != 2'b00) begin
          g = pick(req_valid, m_last[k], (k == 0));
          m_fly[k] = 1; m_age[k] = 1; m_g[k] = g; m_last[k] = g;
          m_op[k] = (g == 1) ? req_op1 : req_op0;
          m_a[k]  = (g == 1) ? req_a1  : req_a0;
          m_b[k]  = (g == 1) ? req_b1  : req_b0;
        end else if (m_fly[k] != 0 && m_age[k] == 1) begin
          m_age[k] = 2;
        end else if (m_fly[k] != 0 && rsp_ready[m_g[k]]) begin
          m_fly[k] = 0;
        end
      end
    end
    @(negedge clk);
    rst = 1'b0; req_valid = 2'b00;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
